// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC sequencer.
// Values are Q2.(N-2); tables are held at N=16 and rescaled.
package cordic_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PX   = 3'd1;
    localparam logic [2:0] S_PY   = 3'd2;
    localparam logic [2:0] S_PZ   = 3'd3;
    localparam logic [2:0] S_PW   = 3'd4;

    localparam int unsigned K_Q14 = 9949;

    localparam int unsigned ATAN_Q14 [14] = '{
        12868, 7596, 4014, 2037, 1023, 512, 256,
        128, 64, 32, 16, 8, 4, 2
    };

    function automatic int unsigned rescale(
        input int unsigned v,
        input int          n
    );
        if (n >= 16)
            return v << (n - 16);
        return (v + (1 << (15 - n))) >> (16 - n);
    endfunction

    function automatic int unsigned k_const(input int n);
        return rescale(K_Q14, n);
    endfunction

    // Past i=13, atan(2^-i) equals 2^-i well below one LSB.
    function automatic int unsigned atan_const(
        input int i,
        input int n
    );
        if (i < 14)
            return rescale(ATAN_Q14[i], n);
        return 1 << (n - 2 - i);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, i -> round(atan(2^-i)).
// Only indices 0..N-3 are meaningful; others read 0.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [IW-1:0] i,
    output logic [N-1:0]  atan
);

    always_comb begin
        atan = '0;
        for (int k = 0; k < N - 2; k++) begin
            if (int'(i) == k)
                atan = N'(atan_const(k, N));
        end
    end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Rotation-mode CORDIC sequencer sharing one external add_sub.
// Each iteration issues X, Y, Z updates then commits in P_W.
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int N    = 16,
    parameter int ITER = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] angle_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] cos_out,
    output logic [N-1:0] sin_out,
    output logic [N-1:0] as_x,
    output logic [N-1:0] as_y,
    output logic         as_a_s,
    input  logic [N-1:0] as_result
);

    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [IW-1:0] LAST = IW'(ITER - 1);
    localparam logic [N-1:0]  K_VAL = N'(k_const(N));

    logic [2:0]          state;
    logic [IW-1:0]       i;
    logic signed [N-1:0] x;
    logic signed [N-1:0] y;
    logic [N-1:0]        z;
    logic [N-1:0]        xn;
    logic [N-1:0]        yn;
    logic [N-1:0]        atan;
    logic                d_pos;
    logic                last;
    logic                accept;

    cordic_atan_rom #(
        .N  (N),
        .IW (IW)
    ) u_rom (
        .i    (i),
        .atan (atan)
    );

    assign d_pos = ~z[N-1];
    assign last  = (state == S_PW) && (i == LAST);

    // The final commit edge may reload, so held start runs back-to-back.
    assign accept = start && ((state == S_IDLE) || last);

    always_comb begin
        as_x   = '0;
        as_y   = '0;
        as_a_s = 1'b0;
        unique case (state)
            S_PX: begin
                as_x   = x;
                as_y   = x_shift_src(y);
                as_a_s = d_pos;
            end
            S_PY: begin
                as_x   = y;
                as_y   = x_shift_src(x);
                as_a_s = ~d_pos;
            end
            S_PZ: begin
                as_x   = z;
                as_y   = atan;
                as_a_s = d_pos;
            end
            default: ;
        endcase
    end

    function automatic logic [N-1:0] x_shift_src(
        input logic signed [N-1:0] v
    );
        return v >>> i;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            i       <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            xn      <= '0;
            yn      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: ;
                S_PX: state <= S_PY;
                S_PY: begin
                    xn    <= as_result;
                    state <= S_PZ;
                end
                S_PZ: begin
                    yn    <= as_result;
                    state <= S_PW;
                end
                S_PW: begin
                    z <= as_result;
                    x <= xn;
                    y <= yn;
                    if (i == LAST) begin
                        cos_out <= xn;
                        sin_out <= yn;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        i     <= i + IW'(1);
                        state <= S_PX;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (accept) begin
                x     <= K_VAL;
                y     <= '0;
                z     <= angle_in;
                i     <= '0;
                busy  <= 1'b1;
                state <= S_PX;
            end
        end
    end

endmodule
